// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Provides the clear-sequencer state type and the address-width helper.
package regfile_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } rf_state_t;

   function automatic int rf_aw(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: NRD read ports, one write port, debug tap.
// master drives addresses/enables/data, slave returns read data and ready.
interface reg_file_mp_if
   import regfile_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREGS = 16,
   parameter int NRD   = 2
);

   localparam int AW = rf_aw(NREGS);

   logic [NRD*AW-1:0]    rd_addr;
   logic [NRD-1:0]       rd_en_n;
   logic [NRD*WIDTH-1:0] rd_data;
   logic [AW-1:0]        wr_addr;
   logic [WIDTH-1:0]     wr_data;
   logic                 wr_en_n;
   logic                 ready;
   logic [AW-1:0]        dbg_sel;
   logic [WIDTH-1:0]     dbg_data;

   modport master (
      output rd_addr, rd_en_n, wr_addr, wr_data, wr_en_n, dbg_sel,
      input  rd_data, ready, dbg_data
   );

   modport slave (
      input  rd_addr, rd_en_n, wr_addr, wr_data, wr_en_n, dbg_sel,
      output rd_data, ready, dbg_data
   );

endinterface

// File: rtl/reg_file_mp_clear_seq.sv
// Post-reset clear sequencer: sweeps every register to zero, then flags ready.
// Ports: clk, rst (sync, active-high), o_ready, o_clr_we, o_clr_addr.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int NREGS = 16,
   parameter int AW    = rf_aw(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   output logic          o_ready,
   output logic          o_clr_we,
   output logic [AW-1:0] o_clr_addr
);

   rf_state_t     r_state;
   logic [AW-1:0] r_ptr;
   logic          r_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= CLEAR;
         r_ptr   <= '0;
         r_ready <= 1'b0;
      end else begin
         unique case (r_state)
            CLEAR: begin
               r_ptr <= r_ptr + 1'b1;
               // last register cleared on this edge
               if (r_ptr == AW'(NREGS - 1)) begin
                  r_state <= RUN;
                  r_ready <= 1'b1;
               end
            end
            RUN: begin
               r_state <= RUN;
            end
         endcase
      end
   end

   assign o_ready    = r_ready;
   assign o_clr_we   = (r_state == CLEAR);
   assign o_clr_addr = r_ptr;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NRD async read ports, one sync write port, debug tap.
// Ports: clk, rst (sync, active-high), bus (reg_file_mp_if.slave).
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through to read ports.
module reg_file_mp
   import regfile_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter int               NREGS    = 16,
   parameter int               NRD      = 2,
   parameter logic [WIDTH-1:0] IDLE_VAL = '1,
   parameter bit               R0_ZERO  = 1'b1
) (
   input logic          clk,
   input logic          rst,
   reg_file_mp_if.slave bus
);

   localparam int AW = rf_aw(NREGS);

   logic [WIDTH-1:0]          r_mem [NREGS];
   logic                      w_ready;
   logic                      w_clr_we;
   logic [AW-1:0]             w_clr_addr;
   logic                      w_usr_we;
   logic [NRD-1:0][WIDTH-1:0] w_rd;

   regfile_clear_seq #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_clr (
      .clk        (clk),
      .rst        (rst),
      .o_ready    (w_ready),
      .o_clr_we   (w_clr_we),
      .o_clr_addr (w_clr_addr)
   );

   // user writes only land in RUN, never on a reset edge, never to a hard r0
   assign w_usr_we = !rst && w_ready && !bus.wr_en_n &&
                     !(R0_ZERO && (bus.wr_addr == '0));

   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[w_clr_addr] <= '0;
      end else if (w_usr_we) begin
         r_mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] w_a;
      logic          w_z;
      logic          w_hit;

      assign w_a = bus.rd_addr[gi*AW +: AW];
      assign w_z = R0_ZERO && (w_a == '0);

`ifdef REGFILE_BYPASS_EN
      assign w_hit = !bus.wr_en_n && (w_a == bus.wr_addr);
`else
      assign w_hit = 1'b0;
`endif

      always_comb begin
         w_rd[gi] = IDLE_VAL;
         if (!bus.rd_en_n[gi] && w_ready) begin
            if (w_z) begin
               w_rd[gi] = '0;
            end else if (w_hit) begin
               w_rd[gi] = bus.wr_data;
            end else begin
               w_rd[gi] = r_mem[w_a];
            end
         end
      end
   end

   assign bus.rd_data  = w_rd;
   assign bus.ready    = w_ready;
   assign bus.dbg_data = (R0_ZERO && (bus.dbg_sel == '0)) ? '0
                                                          : r_mem[bus.dbg_sel];

endmodule
